// File: rtl/onehot_decoder_if.sv
// Handshake bundle for the registered binary-to-one-hot decoder.
// The master drives index requests and consumes results.
interface onehot_decoder_if #(
    parameter int WIDTH    = 86,
    parameter int IDX_W    = 7,
    parameter int ERRCNT_W = 8
);
    logic                en;
    logic                in_valid;
    logic                in_ready;
    logic [IDX_W-1:0]    binary_in;
    logic                acc_mode;
    logic                clear;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    decoder_out;
    logic                err;
    logic [WIDTH-1:0]    mask_out;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output en,
        output in_valid,
        output binary_in,
        output acc_mode,
        output clear,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  decoder_out,
        input  err,
        input  mask_out,
        input  err_count
    );

    modport slave (
        input  en,
        input  in_valid,
        input  binary_in,
        input  acc_mode,
        input  clear,
        input  out_ready,
        output in_ready,
        output out_valid,
        output decoder_out,
        output err,
        output mask_out,
        output err_count
    );
endinterface

// File: rtl/onehot_decoder.sv
// Registered binary-to-one-hot decoder with occupancy mask and
// saturating out-of-range counter; single-entry output register.
module onehot_decoder #(
    parameter int WIDTH    = 86,
    parameter int IDX_W    = 7,
    parameter int ERRCNT_W = 8
) (
    input logic          clk,
    input logic          rst,
    onehot_decoder_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic             accept;
    logic             legal;
    logic [WIDTH-1:0] onehot;

    // Ready when enabled, out of reset and the slot is free or draining.
    assign bus.in_ready = bus.en & ~rst &
                          (~bus.out_valid | bus.out_ready);

    assign accept = bus.in_valid & bus.in_ready;

    assign legal = 32'(bus.binary_in) < 32'(WIDTH);

    // Decode the index; out-of-range indices yield an all-zero word.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onehot[i] = (32'(bus.binary_in) == 32'(i));
        end
    end

    // Output slot: capture on accept, release on consume without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= EMPTY;
            bus.out_valid   <= 1'b0;
            bus.decoder_out <= '0;
            bus.err         <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state           <= FULL;
                        bus.out_valid   <= 1'b1;
                        bus.decoder_out <= onehot;
                        bus.err         <= ~legal;
                    end
                end
                FULL: begin
                    if (accept) begin
                        bus.decoder_out <= onehot;
                        bus.err         <= ~legal;
                    end else if (bus.out_ready) begin
                        state         <= EMPTY;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy mask and error count; clear wins over same-cycle updates.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            bus.mask_out  <= '0;
            bus.err_count <= '0;
        end else if (accept) begin
            if (legal && bus.acc_mode) begin
                bus.mask_out <= bus.mask_out | onehot;
            end
            if (!legal && (bus.err_count != '1)) begin
                bus.err_count <= bus.err_count + ERRCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_onehot_decoder.sv
// Scoreboard bench for onehot_decoder: driver pushes expected results,
// a monitor pops and compares whenever a result is consumed.
module tb_onehot_decoder;

    localparam int WIDTH    = 86;
    localparam int IDX_W    = 7;
    localparam int ERRCNT_W = 8;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    onehot_decoder_if #(
        .WIDTH(WIDTH), .IDX_W(IDX_W), .ERRCNT_W(ERRCNT_W)
    ) bus ();

    onehot_decoder #(
        .WIDTH(WIDTH), .IDX_W(IDX_W), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   known = 0;
    bit   m_full = 0;
    bit   m_mask[WIDTH];
    int   m_cnt = 0;

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] mask_vec();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++) v[i] = m_mask[i];
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] bit_of(input int i);
        logic [WIDTH-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // One clock of stimulus plus reference-model update.
    task automatic step(input bit e, input bit iv, input int idx,
                        input bit acc, input bit clr,
                        input bit ordy, input bit r);
        bit   rdy;
        bit   acc_now;
        exp_t x;
        @(negedge clk);
        rst           = r;
        bus.en        = e;
        bus.in_valid  = iv;
        bus.binary_in = IDX_W'(idx);
        bus.acc_mode  = acc;
        bus.clear     = clr;
        bus.out_ready = ordy;
        #1;
        rdy = e && !r && (!m_full || ordy);
        check("in_ready", 128'(bus.in_ready), 128'(rdy));
        if (known) begin
            check("out_valid", 128'(bus.out_valid), 128'(m_full));
            check("mask_out", 128'(bus.mask_out), 128'(mask_vec()));
            check("err_count", 128'(bus.err_count), 128'(m_cnt));
        end
        acc_now = iv && rdy;
        if (acc_now) begin
            x.word = '0;
            x.err  = (idx >= WIDTH);
            if (!x.err) x.word[idx] = 1'b1;
            sb.push_back(x);
        end
        if (r && m_full && sb.size() > 0) void'(sb.pop_front());
        @(posedge clk);
        if (r) begin
            m_full = 0;
            foreach (m_mask[i]) m_mask[i] = 0;
            m_cnt = 0;
            known = 1;
        end else begin
            if (acc_now) m_full = 1;
            else if (ordy) m_full = 0;
            if (clr) begin
                foreach (m_mask[i]) m_mask[i] = 0;
                m_cnt = 0;
            end else if (acc_now) begin
                if (idx < WIDTH) begin
                    if (acc) m_mask[idx] = 1;
                end else if (m_cnt < 255) begin
                    m_cnt++;
                end
            end
        end
    endtask

    // Monitor: compare every consumed result against the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b1 && bus.out_valid === 1'b1 &&
                bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %h, expected none",
                             bus.decoder_out);
                end else begin
                    x = sb.pop_front();
                    check("decoder_out", 128'(bus.decoder_out),
                          128'(x.word));
                    check("err", 128'(bus.err), 128'(x.err));
                end
            end
        end
    end

    initial begin
        int idx;
        bus.en = 0; bus.in_valid = 0; bus.binary_in = '0;
        bus.acc_mode = 0; bus.clear = 0; bus.out_ready = 0;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // sweep of all legal indices, one per cycle
        for (int i = 0; i < WIDTH; i++) step(1, 1, i, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);

        // illegal indices and counter saturation
        step(1, 1, 86, 0, 0, 1, 0);
        step(1, 1, 127, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        check("err_count_two", 128'(bus.err_count), 128'(2));
        for (int i = 0; i < 300; i++)
            step(1, 1, 86 + $urandom_range(0, 41), 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        check("err_count_sat", 128'(bus.err_count), 128'(255));
        step(1, 0, 0, 0, 1, 1, 0);

        // backpressure: hold bit5 while index 9 waits
        step(1, 1, 5, 0, 0, 1, 0);
        #1 check("hold_first", 128'(bus.decoder_out), 128'(bit_of(5)));
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 9, 0, 0, 0, 0);
            #1 check("hold_bit5", 128'(bus.decoder_out), 128'(bit_of(5)));
        end
        step(1, 1, 9, 0, 0, 1, 0);
        #1 check("next_bit9", 128'(bus.decoder_out), 128'(bit_of(9)));
        step(1, 0, 0, 0, 0, 1, 0);

        // accumulate then clear alongside an accept
        step(1, 1, 0, 1, 0, 1, 0);
        step(1, 1, 3, 1, 0, 1, 0);
        step(1, 1, 85, 1, 0, 1, 0);
        step(1, 1, 3, 1, 0, 1, 0);
        #1 check("mask_set", 128'(bus.mask_out),
                 128'(bit_of(0) | bit_of(3) | bit_of(85)));
        step(1, 1, 100, 1, 0, 1, 0);
        step(1, 1, 7, 1, 1, 1, 0);
        #1 check("clr_mask", 128'(bus.mask_out), 128'(0));
        check("clr_cnt", 128'(bus.err_count), 128'(0));
        check("clr_dec", 128'(bus.decoder_out), 128'(bit_of(7)));
        step(1, 0, 0, 0, 0, 1, 0);

        // enable gating: drain while disabled, nothing new accepted
        step(1, 1, 20, 0, 0, 0, 0);
        step(0, 1, 21, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 21, 0, 0, 1, 0);
        step(1, 1, 21, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);

        // reset while full with a nonzero mask
        step(1, 1, 40, 1, 0, 0, 0);
        step(1, 1, 41, 1, 0, 0, 1);
        step(1, 1, 42, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            idx = ($urandom_range(0, 3) == 0) ?
                  $urandom_range(86, 127) : $urandom_range(0, 85);
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                 idx, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0);
        end

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0);
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
